sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO for intra-domain buffering. It is the same-clock successor of `async_fifo` and keeps its port naming and `DEPTH`/`DATA_WIDTH`/`ADDR_WIDTH`/`OUTPUT_REG`/`RAM_TYPE` parameters. It adds an exact fill count, programmable almost-full/almost-empty flags and a first-word-fall-through (FWFT) mode. It sits between producer/consumer pipelines that share `clk`, where synchronizer latency is unwanted.

## Interface
- `DEPTH`, 16, number of entries; must equal 2**`ADDR_WIDTH` (elaboration error otherwise)
- `DATA_WIDTH`, 32, word width
- `ADDR_WIDTH`, 4, address bits
- `OUTPUT_REG`, 1, standard mode only: adds one output register stage; must be 0 when `FWFT`=1 (elaboration error otherwise)
- `RAM_TYPE`, "block", memory style: block | distributed | register | ultra
- `FWFT`, 0, 1 = head word presented on `rd_data` without a read request
- `AFULL_THRESH`, DEPTH-2, `almost_full_out` asserts when count >= value; legal range 1..DEPTH
- `AEMPTY_THRESH`, 2, `almost_empty_out` asserts when count <= value; legal range 0..DEPTH-1
- `clk` in 1: single clock, all logic on rising edge
- `rst_glb` in 1: synchronous, active-high reset
- `wr_en` in 1: write request
- `wr_data` in DATA_WIDTH: write word
- `full_out` out 1: count == DEPTH
- `almost_full_out` out 1: count >= AFULL_THRESH
- `rd_en` in 1: read request; in FWFT mode, pop of the displayed head
- `rd_data` out DATA_WIDTH: read word
- `empty_out` out 1: no word available to read
- `almost_empty_out` out 1: count <= AEMPTY_THRESH
- `count_out` out ADDR_WIDTH+1: number of words stored, 0..DEPTH

## Operation
- Write accepted iff `wr_en` && !`full_out`. Read accepted iff `rd_en` && !`empty_out`. The two conditions are evaluated independently, with no read-through on full.
- Pointers are ADDR_WIDTH+1 bits and wrap naturally.
- Count: +1 on write only, −1 on read only, unchanged on both or neither.
- A rejected request has no effect on memory, pointers, count or `rd_data`.
- Standard mode: `rd_data` holds its last value whenever no read is accepted.
- FWFT mode:
  - A prefetch register holds the head word.
  - `empty_out` reflects the prefetch register's valid bit, not `count_out`.
  - `count_out` includes the prefetched word.
  - A pop refills the register from memory on the same edge when another word is stored.
- Reset (any cycle, including mid-burst):
  - Pointers and count go to 0; `rd_data` goes to 0.
  - Flags go to `empty_out`=1, `full_out`=0, `almost_empty_out`=1, `almost_full_out`=0.
  - Memory contents are not cleared.
  - Requests in the reset cycle are ignored.

## Timing
- All outputs are registered and update on the edge that accepts the request.
- Standard mode:
  - `OUTPUT_REG`=0: `rd_data` is valid after the accepting edge (1-cycle latency).
  - `OUTPUT_REG`=1: `rd_data` is valid after the following edge (2 cycles).
- FWFT mode: a write into an empty FIFO at edge k gives `rd_data` valid and `empty_out`=0 after edge k+1.
- Standard mode: `empty_out` falls after the write edge.
- Boundary cases:
  - Full + `wr_en`: write dropped.
  - Full + both requests: read only, count becomes DEPTH−1.
  - Empty + both requests: write only.
  - Empty + `rd_en`: ignored, `rd_data` held.

## Configuration
- Macro `SYNC_FIFO_ERR_FLAGS_EN`, when defined:
  - Adds output ports `overflow_out` and `underflow_out`, 1 bit each.
  - `overflow_out` is set on `wr_en`&&`full_out`; `underflow_out` is set on `rd_en`&&`empty_out`.
  - Both are sticky until `rst_glb`, set one cycle after the offending edge, reset value 0.
- When undefined, the ports and their logic are absent; all other behaviour is identical.

## Structure
- Package `sync_fifo_pkg`: RAM_TYPE string constants, parameter-check function for power-of-two `DEPTH` and threshold ranges, count width function (ADDR_WIDTH+1).
- Sub-module `sync_fifo_ram`: simple dual-port memory carrying the `RAM_TYPE` synthesis attribute, with an optional output register. It is shared in style with `async_fifo`'s storage.
- Top level holds pointers, count, flags, FWFT prefetch and error flags.

## Test plan
- Reset for 3 cycles -> `empty_out`=1, `full_out`=0, `count_out`=0, `almost_empty_out`=1, `rd_data`=0.
- Defaults, write 0..15 back-to-back, then `wr_en` with 999 -> `full_out`=1 after the 16th edge, `almost_full_out`=1 once count reaches 14, 999 dropped (and `overflow_out`=1 with the macro). Read 16 words -> 0..15 in order at 2-cycle latency; `empty_out`=1; `rd_data` holds 15 afterwards.
- Full FIFO with `wr_en`=`rd_en`=1 for one cycle -> `count_out`=15, head word 0 read. Empty FIFO with both requests -> `count_out`=1 and `rd_data` unchanged (`underflow_out`=1 with the macro).
- `FWFT`=1, `OUTPUT_REG`=0: write 0xA5 at edge k -> `rd_data`=0xA5 and `empty_out`=0 after edge k+1 with no `rd_en`. Pop -> `empty_out`=1, `count_out`=0.
- Wrap-around: 40 cycles of random interleaved writes/reads -> output sequence matches a scoreboard, and `count_out` equals writes minus reads at every edge.
- Assert `rst_glb` mid-burst with count=9 -> next cycle count=0, `empty_out`=1. Writing 7 then reading returns 7, not stale data.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration-time helpers for sync_fifo.
package sync_fifo_pkg;

  localparam string RAM_BLOCK       = "block";
  localparam string RAM_DISTRIBUTED = "distributed";
  localparam string RAM_REGISTER    = "register";
  localparam string RAM_ULTRA       = "ultra";

  function automatic int count_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // DEPTH must be exactly 2**ADDR_WIDTH so the pointers wrap without extra logic.
  function automatic bit params_ok(input int depth, input int addr_w,
                                   input int afull, input int aempty);
    return (depth == (1 << addr_w)) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus of sync_fifo. SYNC_FIFO_ERR_FLAGS_EN adds the sticky error flags.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                             wr_en;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic                             full_out;
  logic                             almost_full_out;
  logic                             rd_en;
  logic [DATA_WIDTH-1:0]            rd_data;
  logic                             empty_out;
  logic                             almost_empty_out;
  logic [count_w(ADDR_WIDTH)-1:0]   count_out;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                             overflow_out;
  logic                             underflow_out;
`endif

  modport master (
    output wr_en, wr_data, rd_en,
    input  full_out, almost_full_out, rd_data, empty_out, almost_empty_out, count_out
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , input overflow_out, underflow_out
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full_out, almost_full_out, rd_data, empty_out, almost_empty_out, count_out
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , output overflow_out, underflow_out
`endif
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage with registered read and an optional second output stage.
module sync_fifo_ram #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 4,
  parameter int    OUTPUT_REG = 1,
  parameter string RAM_TYPE   = "block"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_p0;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Stage 0: memory read register; cleared on reset so rd_data starts at zero.
  always_ff @(posedge clk) begin
    if (rst)       rdata_p0 <= '0;
    else if (re_i) rdata_p0 <= mem_q[raddr_i];
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic                  vld_p0;
      logic [DATA_WIDTH-1:0] rdata_p1;
      // Stage 1: loads only behind a real read so the output holds between reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p0   <= 1'b0;
          rdata_p1 <= '0;
        end else begin
          vld_p0 <= re_i;
          if (vld_p0) rdata_p1 <= rdata_p0;
        end
      end
      assign rdata_o = rdata_p1;
    end else begin : g_noreg
      assign rdata_o = rdata_p0;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact count, almost flags and optional FWFT head register.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int    DEPTH         = 16,
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDR_WIDTH    = 4,
  parameter int    OUTPUT_REG    = 1,
  parameter string RAM_TYPE      = RAM_BLOCK,
  parameter int    FWFT          = 0,
  parameter int    AFULL_THRESH  = DEPTH - 2,
  parameter int    AEMPTY_THRESH = 2
) (
  input  logic       clk,
  input  logic       rst_glb,
  sync_fifo_if.slave bus
);

  localparam int CW = count_w(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  generate
    if (!params_ok(DEPTH, ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
      $error("sync_fifo: DEPTH must be 2**ADDR_WIDTH and thresholds within range");
    end
    if ((FWFT != 0) && (OUTPUT_REG != 0)) begin : g_bad_oreg
      $error("sync_fifo: OUTPUT_REG must be 0 when FWFT is enabled");
    end
  endgenerate

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, afull_q, aempty_q;
  logic          wr_acc, rd_acc, mem_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_acc   = bus.wr_en && !full_q  && !rst_glb;
  assign rd_acc   = bus.rd_en && !empty_q && !rst_glb;
  assign wr_ptr_d = wr_ptr_q + CW'(wr_acc);
  assign rd_ptr_d = rd_ptr_q + CW'(mem_re);

  generate
    if (FWFT != 0) begin : g_fwft
      logic pf_vld_d;
      // The RAM read register doubles as the head register; refill whenever it is
      // free or being popped and memory still holds a word.
      assign mem_re   = (empty_q || rd_acc) && (wr_ptr_q != rd_ptr_q) && !rst_glb;
      assign pf_vld_d = mem_re || (!empty_q && !rd_acc);
      assign empty_d  = !pf_vld_d;
      assign count_d  = (wr_ptr_d - rd_ptr_d) + CW'(pf_vld_d);
    end else begin : g_std
      assign mem_re  = rd_acc;
      assign count_d = wr_ptr_d - rd_ptr_d;
      assign empty_d = (count_d == '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_glb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= (count_d == DEPTH_C);
      afull_q  <= (count_d >= AFULL_C);
      aempty_q <= (count_d <= AEMPTY_C);
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .OUTPUT_REG (OUTPUT_REG),
    .RAM_TYPE   (RAM_TYPE)
  ) u_ram (
    .clk     (clk),
    .rst     (rst_glb),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (bus.wr_data),
    .re_i    (mem_re),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  assign bus.rd_data          = ram_rdata;
  assign bus.count_out        = count_q;
  assign bus.empty_out        = empty_q;
  assign bus.full_out         = full_q;
  assign bus.almost_full_out  = afull_q;
  assign bus.almost_empty_out = aempty_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst_glb) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_q)  ovf_q <= 1'b1;
      if (bus.rd_en && empty_q) udf_q <= 1'b1;
    end
  end

  assign bus.overflow_out  = ovf_q;
  assign bus.underflow_out = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: standard mode (OUTPUT_REG=1) with a scoreboard, plus an FWFT instance.
module tb_sync_fifo;

  logic clk;
  logic rst;

  sync_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) s_if ();
  sync_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) f_if ();

  sync_fifo u_std (
    .clk     (clk),
    .rst_glb (rst),
    .bus     (s_if)
  );

  sync_fifo #(.FWFT(1), .OUTPUT_REG(0)) u_fwft (
    .clk     (clk),
    .rst_glb (rst),
    .bus     (f_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_cnt = 0;
  int          cyc_n = 0;
  logic [31:0] sb[$];
  pend_t       pend[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock on the standard instance; the model decides acceptance from its own count.
  task automatic std_cyc(input logic w, input logic [31:0] d, input logic r);
    logic  wacc, racc;
    pend_t e;
    s_if.wr_en   = w;
    s_if.wr_data = d;
    s_if.rd_en   = r;
    wacc = w && (m_cnt != 16);
    racc = r && (m_cnt != 0);
    if (racc) begin
      e.due  = cyc_n + 2;
      e.data = sb.pop_front();
      pend.push_back(e);
    end
    if (wacc) sb.push_back(d);
    if (wacc && !racc) m_cnt++;
    else if (racc && !wacc) m_cnt--;
    @(posedge clk);
    cyc_n++;
    #1;
    s_if.wr_en = 1'b0;
    s_if.rd_en = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc_n) begin
      e = pend.pop_front();
      chk("rd_data", 64'(s_if.rd_data), 64'(e.data));
    end
    chk("count",  64'(s_if.count_out),        64'(m_cnt));
    chk("empty",  64'(s_if.empty_out),        64'(m_cnt == 0));
    chk("full",   64'(s_if.full_out),         64'(m_cnt == 16));
    chk("afull",  64'(s_if.almost_full_out),  64'(m_cnt >= 14));
    chk("aempty", 64'(s_if.almost_empty_out), 64'(m_cnt <= 2));
  endtask

  task automatic do_reset(input int n, input logic w, input logic r);
    rst          = 1'b1;
    s_if.wr_en   = w;
    s_if.wr_data = 32'hDEAD_BEEF;
    s_if.rd_en   = r;
    repeat (n) begin
      @(posedge clk);
      cyc_n++;
    end
    #1;
    rst        = 1'b0;
    s_if.wr_en = 1'b0;
    s_if.rd_en = 1'b0;
    sb.delete();
    pend.delete();
    m_cnt = 0;
  endtask

  task automatic f_tick();
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.wr_data = '0;
    f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.wr_data = '0;

    // Reset state
    do_reset(3, 1'b0, 1'b0);
    chk("rst_empty",  64'(s_if.empty_out),        64'd1);
    chk("rst_full",   64'(s_if.full_out),         64'd0);
    chk("rst_count",  64'(s_if.count_out),        64'd0);
    chk("rst_aempty", 64'(s_if.almost_empty_out), 64'd1);
    chk("rst_afull",  64'(s_if.almost_full_out),  64'd0);
    chk("rst_rdata",  64'(s_if.rd_data),          64'd0);
    chk("f_rst_empty", 64'(f_if.empty_out),       64'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("rst_ovf", 64'(s_if.overflow_out),  64'd0);
    chk("rst_udf", 64'(s_if.underflow_out), 64'd0);
`endif

    // Fill to full, then a dropped write
    for (int i = 0; i < 16; i++) std_cyc(1'b1, 32'(i), 1'b0);
    chk("full_after16", 64'(s_if.full_out), 64'd1);
    std_cyc(1'b1, 32'd999, 1'b0);
    chk("full_drop_count", 64'(s_if.count_out), 64'd16);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_set", 64'(s_if.overflow_out), 64'd1);
`endif

    // Drain in order, rd_data holds the last word
    for (int i = 0; i < 16; i++) std_cyc(1'b0, 32'd0, 1'b1);
    std_cyc(1'b0, 32'd0, 1'b0);
    std_cyc(1'b0, 32'd0, 1'b0);
    chk("drain_hold15", 64'(s_if.rd_data), 64'd15);
    std_cyc(1'b0, 32'd0, 1'b1);
    chk("empty_rd_hold15", 64'(s_if.rd_data), 64'd15);

    // Full with both requests: read only
    for (int i = 0; i < 16; i++) std_cyc(1'b1, 32'(16 + i), 1'b0);
    std_cyc(1'b1, 32'd777, 1'b1);
    chk("full_both_count", 64'(s_if.count_out), 64'd15);
    for (int i = 0; i < 15; i++) std_cyc(1'b0, 32'd0, 1'b1);
    std_cyc(1'b0, 32'd0, 1'b0);
    std_cyc(1'b0, 32'd0, 1'b0);
    chk("after_drain31", 64'(s_if.rd_data), 64'd31);

    // Empty with both requests: write only
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("udf_clear", 64'(s_if.underflow_out), 64'd0);
`endif
    std_cyc(1'b1, 32'd55, 1'b1);
    chk("empty_both_count", 64'(s_if.count_out), 64'd1);
    chk("empty_both_rdata", 64'(s_if.rd_data),   64'd31);
    std_cyc(1'b0, 32'd0, 1'b0);
    chk("empty_both_rdata2", 64'(s_if.rd_data),  64'd31);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("udf_set", 64'(s_if.underflow_out), 64'd1);
`endif
    std_cyc(1'b0, 32'd0, 1'b1);
    std_cyc(1'b0, 32'd0, 1'b0);
    std_cyc(1'b0, 32'd0, 1'b0);

    // Random interleaving across pointer wrap
    for (int i = 0; i < 40; i++)
      std_cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 16 && m_cnt > 0; i++) std_cyc(1'b0, 32'd0, 1'b1);
    std_cyc(1'b0, 32'd0, 1'b0);
    std_cyc(1'b0, 32'd0, 1'b0);

    // Reset mid-burst with requests held during the reset cycle
    for (int i = 0; i < 9; i++) std_cyc(1'b1, 32'(100 + i), 1'b0);
    chk("midburst_count9", 64'(s_if.count_out), 64'd9);
    do_reset(1, 1'b1, 1'b1);
    chk("mid_rst_count", 64'(s_if.count_out), 64'd0);
    chk("mid_rst_empty", 64'(s_if.empty_out), 64'd1);
    chk("mid_rst_rdata", 64'(s_if.rd_data),   64'd0);
    std_cyc(1'b1, 32'd7, 1'b0);
    std_cyc(1'b0, 32'd0, 1'b1);
    std_cyc(1'b0, 32'd0, 1'b0);
    std_cyc(1'b0, 32'd0, 1'b0);
    chk("post_rst_read7", 64'(s_if.rd_data), 64'd7);

    // FWFT instance
    f_if.wr_en = 1'b1; f_if.wr_data = 32'hA5;
    f_tick();
    f_if.wr_en = 1'b0;
    chk("fwft_k_empty", 64'(f_if.empty_out), 64'd1);
    chk("fwft_k_count", 64'(f_if.count_out), 64'd1);
    f_tick();
    chk("fwft_k1_rdata", 64'(f_if.rd_data),   64'hA5);
    chk("fwft_k1_empty", 64'(f_if.empty_out), 64'd0);
    f_if.rd_en = 1'b1;
    f_tick();
    f_if.rd_en = 1'b0;
    chk("fwft_pop_empty", 64'(f_if.empty_out), 64'd1);
    chk("fwft_pop_count", 64'(f_if.count_out), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      f_if.wr_en = 1'b1; f_if.wr_data = 32'(i);
      f_tick();
    end
    f_if.wr_en = 1'b0;
    f_tick();
    chk("fwft_head1",   64'(f_if.rd_data),   64'd1);
    chk("fwft_count3",  64'(f_if.count_out), 64'd3);
    f_if.rd_en = 1'b1;
    f_tick();
    chk("fwft_refill2", 64'(f_if.rd_data),   64'd2);
    chk("fwft_count2",  64'(f_if.count_out), 64'd2);
    chk("fwft_nempty",  64'(f_if.empty_out), 64'd0);
    f_tick();
    chk("fwft_refill3", 64'(f_if.rd_data),   64'd3);
    f_tick();
    f_if.rd_en = 1'b0;
    chk("fwft_last_empty", 64'(f_if.empty_out), 64'd1);
    chk("fwft_last_count", 64'(f_if.count_out), 64'd0);
    chk("fwft_last_hold",  64'(f_if.rd_data),   64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
